pwm_peripheral: RTL and testbench

- Downstream consumer of the SPI register block: takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives the 16 user output pins.
- Each pin is one of: held low, held high, or a shared PWM waveform.
- Single shared 8-bit PWM counter, advanced by a clock prescaler.
- Duty cycle is double-buffered so a change only takes effect at a PWM period boundary (glitch-free).

---
 rtl/pwm_peripheral.sv | 85 ++++++++
 tb/tb_pwm_peripheral.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// Drives 16 user pins from the register block: each pin is low, high, or a shared PWM waveform.
// One prescaled 8-bit counter feeds all pins; the duty value is reloaded only at the period wrap.
module pwm_peripheral #(
  parameter int CLK_DIV = 13,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] duty_l;
  logic             tick;
  logic             wrap;
  logic             wrap_q;
  logic             pwm_sig;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_next;

  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (pwm_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The wrap edge also reloads the duty buffer, so a new period never sees a half-applied duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_l  <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) begin
        duty_l <= CNT_W'(pwm_duty_cycle);
      end
    end
  end

  // Full scale is special-cased so 0xFF means continuously on rather than 255/256.
  always_comb begin
    pwm_sig = 1'b0;
    if (duty_l == {CNT_W{1'b1}}) begin
      pwm_sig = 1'b1;
    end else begin
      pwm_sig = (pwm_cnt < duty_l);
    end
  end

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_next = en_out & (~en_pwm | {16{pwm_sig}});

  // wrap_q delays the pulse one clk so it lines up with out first showing pwm_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      wrap_q       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      wrap_q       <= wrap;
      period_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: a CLK_DIV=2 instance for most steps and a CLK_DIV=1
// instance for the fast-wrap step; expected values queue up as stimulus is applied.
module tb_pwm_peripheral;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out0, out1;
  logic        ps0, ps1;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  pwm_peripheral #(.CLK_DIV(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out0), .period_start(ps0)
  );

  pwm_peripheral #(.CLK_DIV(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      want = exp_q.pop_front();
      assert (obs === want) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
    end
  endtask

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    eo_hi = eo[15:8];
    eo_lo = eo[7:0];
    ep_hi = ep[15:8];
    ep_lo = ep[7:0];
    duty  = d;
  endtask

  // Advance at least one clk, stop on the negedge where period_start is seen.
  task automatic wait_ps(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? ps1 : ps0) && n < 4000);
    expect_val(W'(1));
    sb_check(sel ? "ps1_seen" : "ps0_seen", W'(sel ? ps1 : ps0));
  endtask

  // Entered on a period_start cycle; counts pin 0 high/low clks and toggles up to the next one.
  task automatic measure(input bit sel, input int change_at, input logic [7:0] new_duty,
                         output int hi, output int lo, output int tg);
    logic prev;
    logic cur;
    int   c;
    hi = 0;
    lo = 0;
    tg = 0;
    c  = 0;
    prev = sel ? out1[0] : out0[0];
    do begin
      cur = sel ? out1[0] : out0[0];
      if (cur) hi++;
      else lo++;
      if (c > 0 && cur != prev) tg++;
      prev = cur;
      if (c == change_at) duty = new_duty;
      @(negedge clk);
      c++;
    end while (!(sel ? ps1 : ps0) && c < 4000);
  endtask

  initial begin
    int n, hi, lo, tg, static_bad, pwm_bad;

    // Reset values and first-period latency
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    #12;
    expect_val(W'(0));  sb_check("rst_out", W'(out0));
    expect_val(W'(0));  sb_check("rst_ps", W'(ps0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_val(W'(0));  sb_check("duty_l_reset", W'(out0));
    wait_ps(1'b0, n);
    expect_val(W'(503)); sb_check("first_ps_latency", W'(n));
    expect_val(W'(16'hFFFF)); sb_check("pwm_after_wrap", W'(out0));
    #2 rst_n = 1'b0;
    #1;
    expect_val(W'(0));  sb_check("async_rst_out", W'(out0));
    expect_val(W'(0));  sb_check("async_rst_ps", W'(ps0));
    @(negedge clk);
    rst_n = 1'b1;

    // Static modes
    set_regs(16'h00FF, 16'h0000, 8'h80);
    @(negedge clk);
    expect_val(W'(16'h00FF)); sb_check("static_high", W'(out0));
    expect_val(W'(16'h00FF)); sb_check("static_high_div1", W'(out1));
    set_regs(16'h0000, 16'hFFFF, 8'h80);
    @(negedge clk);
    expect_val(W'(0)); sb_check("disabled_low", W'(out0));

    // Duty accuracy at 0x40, 0x00, 0xFF
    set_regs(16'h0001, 16'h0001, 8'h40);
    wait_ps(1'b0, n);
    measure(1'b0, -1, 8'h00, hi, lo, tg);
    expect_val(W'(128)); sb_check("d40_high", W'(hi));
    expect_val(W'(384)); sb_check("d40_low", W'(lo));
    expect_val(W'(1));   sb_check("d40_toggles", W'(tg));
    duty = 8'h00;
    wait_ps(1'b0, n);
    measure(1'b0, -1, 8'h00, hi, lo, tg);
    expect_val(W'(0));   sb_check("d00_high", W'(hi));
    expect_val(W'(512)); sb_check("d00_low", W'(lo));
    duty = 8'hFF;
    wait_ps(1'b0, n);
    measure(1'b0, -1, 8'hFF, hi, lo, tg);
    expect_val(W'(512)); sb_check("dff_high", W'(hi));
    expect_val(W'(0));   sb_check("dff_low", W'(lo));
    expect_val(W'(0));   sb_check("dff_toggles", W'(tg));

    // Double buffering: change mid-period, takes effect next period only
    duty = 8'h40;
    wait_ps(1'b0, n);
    measure(1'b0, 200, 8'hC0, hi, lo, tg);
    expect_val(W'(128)); sb_check("dbuf_cur_high", W'(hi));
    expect_val(W'(384)); sb_check("dbuf_cur_low", W'(lo));
    expect_val(W'(1));   sb_check("dbuf_cur_toggles", W'(tg));
    measure(1'b0, -1, 8'hC0, hi, lo, tg);
    expect_val(W'(384)); sb_check("dbuf_next_high", W'(hi));
    expect_val(W'(128)); sb_check("dbuf_next_low", W'(lo));
    expect_val(W'(1));   sb_check("dbuf_next_toggles", W'(tg));

    // Mixed pins: PWM on en_out & en_pwm = 0xA0A0, static high on en_out & ~en_pwm = 0x0505
    set_regs(16'hA5A5, 16'hF0F0, 8'h80);
    wait_ps(1'b0, n);
    static_bad = 0;
    pwm_bad    = 0;
    hi         = 0;
    for (int i = 0; i < 512; i++) begin
      if ((out0 & 16'h5F5F) != 16'h0505) static_bad++;
      if ((out0 & 16'hA0A0) != 16'h0000 && (out0 & 16'hA0A0) != 16'hA0A0) pwm_bad++;
      if (out0[15]) hi++;
      @(negedge clk);
    end
    expect_val(W'(0));   sb_check("mixed_static", W'(static_bad));
    expect_val(W'(0));   sb_check("mixed_pwm_equal", W'(pwm_bad));
    expect_val(W'(256)); sb_check("mixed_pwm_high", W'(hi));
    expect_val(W'(1));   sb_check("mixed_period_end", W'(ps0));

    // CLK_DIV=1: 256-clk periods, 1-clk pulse, duty 0x01 gives one high clk
    set_regs(16'h0001, 16'h0001, 8'h01);
    wait_ps(1'b1, n);
    for (int p = 0; p < 2; p++) begin
      measure(1'b1, -1, 8'h01, hi, lo, tg);
      expect_val(W'(1));   sb_check("div1_high", W'(hi));
      expect_val(W'(256)); sb_check("div1_period", W'(hi + lo));
    end
    @(negedge clk);
    expect_val(W'(0)); sb_check("div1_ps_width", W'(ps1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
